// File: rtl/spi_word_receiver.sv
// -----------------------------------------------------------------------------
// spi_word_receiver
//
// SPI slave receiver that runs entirely in the system clock domain. SCK, SDI
// and CS are brought in through two-flop synchronisers. The SCK sample edge is
// found by comparing the synchronised SCK with a third, delayed copy. Words of
// DATA_BITS bits are assembled in either bit order. Each completed word is
// pushed into a first-word-fall-through FIFO, which the consumer drains with a
// valid/ready handshake.
//
// Parameters
//   DATA_BITS  : bits per word (2..32)
//   CPOL       : SCK idle level
//   CPHA       : 0 = sample on leading SCK edge, 1 = sample on trailing edge
//   MSB_FIRST  : 1 = first bit lands in bit DATA_BITS-1, 0 = lands in bit 0
//   FIFO_DEPTH : output FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   sck/sdi/cs : raw SPI pins, asynchronous to clk (cs active-high)
//   rxReady    : consumer accepts rxData this cycle
//   clrErr     : one-cycle pulse clearing overflow and frameErr
//   rxData     : oldest FIFO word, or 0 when the FIFO is empty
//   rxValid    : FIFO not empty
//   fifoCount  : number of FIFO entries
//   overflow   : sticky, a completed word was dropped because the FIFO was full
//   frameErr   : sticky, cs went low with a partial word in the shifter
//   busy       : receiver is in the SHIFT state
// -----------------------------------------------------------------------------
module spi_word_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck,
  input  logic                          sdi,
  input  logic                          cs,
  input  logic                          rxReady,
  input  logic                          clrErr,
  output logic [DATA_BITS-1:0]          rxData,
  output logic                          rxValid,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow,
  output logic                          frameErr,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic             SCK_IDLE    = (CPOL != 0);
  // Leading edge is rising for CPOL=0, so CPOL==CPHA always means rising.
  localparam logic             SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchroniser flops
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic sdi_meta_q, sdi_sync_q;
  logic cs_meta_q,  cs_sync_q;
  logic sck_meta_d, sck_sync_d, sck_prev_d;
  logic sdi_meta_d, sdi_sync_d;
  logic cs_meta_d,  cs_sync_d;

  // Receiver state
  state_t                 state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // Holds the DATA_BITS-1 bits received so far; the last bit is merged on
  // the fly so the completed word never needs a separate register.
  logic [DATA_BITS-2:0]   partial_q, partial_d;
  logic [DATA_BITS-1:0]   shifted_s;
  logic                   sample_s;
  logic                   commit_s;
  logic                   frame_set_s;

  // FIFO
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   pop_s, push_s, full_s, ovf_set_s;

  // Flags and status
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  // Synchroniser next values and sample-edge detection
  always_comb begin
    sck_meta_d = sck;
    sck_sync_d = sck_meta_q;
    sck_prev_d = sck_sync_q;
    sdi_meta_d = sdi;
    sdi_sync_d = sdi_meta_q;
    cs_meta_d  = cs;
    cs_sync_d  = cs_meta_q;
    if (SAMPLE_RISE) begin
      sample_s = sck_sync_q & ~sck_prev_q;
    end else begin
      sample_s = ~sck_sync_q & sck_prev_q;
    end
  end

  // Word assembly in the selected bit order
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      always_comb begin
        shifted_s = {partial_q, sdi_sync_q};
      end
    end else begin : g_lsb_first
      always_comb begin
        shifted_s = {sdi_sync_q, partial_q};
      end
    end
  endgenerate

  // Receiver next-state logic: IDLE waits for cs, SHIFT counts sample edges
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    partial_d   = partial_q;
    commit_s    = 1'b0;
    frame_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_sync_q) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!cs_sync_q) begin
          // cs low wins over a coincident sample edge; any partial word is lost
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) begin
            frame_set_s = 1'b1;
          end else begin
            frame_set_s = 1'b0;
          end
        end else if (sample_s) begin
          if (MSB_FIRST != 0) begin
            partial_d = shifted_s[DATA_BITS-2:0];
          end else begin
            partial_d = shifted_s[DATA_BITS-1:1];
          end
          if (bit_cnt_q == LAST_BIT) begin
            // Counter wraps straight to 0 so the next edge is bit 0 of a new word
            commit_s  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // FIFO control: a pop in the commit cycle frees the slot for the new word
  always_comb begin
    mem_d     = mem_q;
    pop_s     = rx_valid_q & rxReady;
    full_s    = (count_q == FULL_CNT);
    push_s    = commit_s & (~full_s | pop_s);
    ovf_set_s = commit_s & full_s & ~pop_s;
    if (push_s) begin
      mem_d[wr_ptr_q] = shifted_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    rx_valid_d = (count_d != '0);
  end

  // Sticky flags (set beats clear) and busy status
  always_comb begin
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clrErr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (frame_set_s) begin
      frame_err_d = 1'b1;
    end else if (clrErr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    busy_d = (state_d == ST_SHIFT);
  end

  // Synchroniser registers; SCK copies reset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta_q <= SCK_IDLE;
      sck_sync_q <= SCK_IDLE;
      sck_prev_q <= SCK_IDLE;
      sdi_meta_q <= 1'b0;
      sdi_sync_q <= 1'b0;
      cs_meta_q  <= 1'b0;
      cs_sync_q  <= 1'b0;
    end else begin
      sck_meta_q <= sck_meta_d;
      sck_sync_q <= sck_sync_d;
      sck_prev_q <= sck_prev_d;
      sdi_meta_q <= sdi_meta_d;
      sdi_sync_q <= sdi_sync_d;
      cs_meta_q  <= cs_meta_d;
      cs_sync_q  <= cs_sync_d;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      partial_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      partial_q <= partial_d;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Flag and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // FWFT read port: head entry, forced to 0 while empty
  always_comb begin
    if (rx_valid_q) begin
      rxData = mem_q[rd_ptr_q];
    end else begin
      rxData = '0;
    end
  end

  assign rxValid   = rx_valid_q;
  assign fifoCount = count_q;
  assign overflow  = overflow_q;
  assign frameErr  = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_word_receiver
//
// Directed bench for spi_word_receiver. Five instances share one SPI wire
// stream: index 0 is mode 0 MSB-first (the main device under test), 1..3
// cover the other CPOL/CPHA modes, and 4 is mode 0 LSB-first. CPOL=1
// instances see the inverted SCK. clk runs at 8x SCK.
// -----------------------------------------------------------------------------
module tb_spi_word_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sck_a, sck_b, sdi, cs;
  logic rdy_0, rdy_o, clr_0;
  assign sck_b = ~sck_a;

  logic [7:0] rx_data    [5];
  logic       rx_valid   [5];
  logic [2:0] fifo_count [5];
  logic       ovf        [5];
  logic       ferr       [5];
  logic       busy       [5];

  int vectors     = 0;
  int miscompares = 0;
  int lat;

  spi_word_receiver #(.DATA_BITS(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_m0 (
    .clk(clk), .rst(rst), .sck(sck_a), .sdi(sdi), .cs(cs), .rxReady(rdy_0), .clrErr(clr_0),
    .rxData(rx_data[0]), .rxValid(rx_valid[0]), .fifoCount(fifo_count[0]),
    .overflow(ovf[0]), .frameErr(ferr[0]), .busy(busy[0]));

  spi_word_receiver #(.DATA_BITS(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_m1 (
    .clk(clk), .rst(rst), .sck(sck_a), .sdi(sdi), .cs(cs), .rxReady(rdy_o), .clrErr(1'b0),
    .rxData(rx_data[1]), .rxValid(rx_valid[1]), .fifoCount(fifo_count[1]),
    .overflow(ovf[1]), .frameErr(ferr[1]), .busy(busy[1]));

  spi_word_receiver #(.DATA_BITS(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_m2 (
    .clk(clk), .rst(rst), .sck(sck_b), .sdi(sdi), .cs(cs), .rxReady(rdy_o), .clrErr(1'b0),
    .rxData(rx_data[2]), .rxValid(rx_valid[2]), .fifoCount(fifo_count[2]),
    .overflow(ovf[2]), .frameErr(ferr[2]), .busy(busy[2]));

  spi_word_receiver #(.DATA_BITS(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_m3 (
    .clk(clk), .rst(rst), .sck(sck_b), .sdi(sdi), .cs(cs), .rxReady(rdy_o), .clrErr(1'b0),
    .rxData(rx_data[3]), .rxValid(rx_valid[3]), .fifoCount(fifo_count[3]),
    .overflow(ovf[3]), .frameErr(ferr[3]), .busy(busy[3]));

  spi_word_receiver #(.DATA_BITS(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
    .clk(clk), .rst(rst), .sck(sck_a), .sdi(sdi), .cs(cs), .rxReady(rdy_o), .clrErr(1'b0),
    .rxData(rx_data[4]), .rxValid(rx_valid[4]), .fifoCount(fifo_count[4]),
    .overflow(ovf[4]), .frameErr(ferr[4]), .busy(busy[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: data stable 2 clk before the leading edge and 2 clk after
  // the trailing edge, SCK high/low for 4 clk each (8 clk per SCK period).
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = w[7-i];
      wait_clk(2);
      sck_a = 1'b1;
      wait_clk(4);
      sck_a = 1'b0;
      wait_clk(2);
    end
  endtask

  task automatic frame_start();
    cs = 1'b1;
    wait_clk(4);
  endtask

  task automatic frame_end();
    wait_clk(2);
    cs = 1'b0;
    wait_clk(6);
  endtask

  task automatic pop0();
    rdy_0 = 1'b1;
    wait_clk(1);
    rdy_0 = 1'b0;
  endtask

  task automatic pop_all();
    rdy_0 = 1'b1;
    rdy_o = 1'b1;
    wait_clk(1);
    rdy_0 = 1'b0;
    rdy_o = 1'b0;
  endtask

  task automatic drain_others();
    rdy_o = 1'b1;
    wait_clk(6);
    rdy_o = 1'b0;
  endtask

  // Watchdog: the directed sequence is a few thousand clocks long
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; sck_a = 1'b0; sdi = 1'b0; cs = 1'b0;
    rdy_0 = 1'b0; rdy_o = 1'b0; clr_0 = 1'b0;
    wait_clk(3);

    // Reset state
    check("rst_valid", 32'(rx_valid[0]),   32'd0);
    check("rst_data",  32'(rx_data[0]),    32'd0);
    check("rst_count", 32'(fifo_count[0]), 32'd0);
    check("rst_ovf",   32'(ovf[0]),        32'd0);
    check("rst_ferr",  32'(ferr[0]),       32'd0);
    check("rst_busy",  32'(busy[0]),       32'd0);
    rst = 1'b0;
    wait_clk(3);

    // Mode 0 frame 0xA5 with latency bound on the final rising edge
    frame_start();
    check("a_busy", 32'(busy[0]), 32'd1);
    send_bits(8'hA5, 7);
    sdi = 1'b1;
    wait_clk(2);
    sck_a = 1'b1;
    lat = 0;
    while (!rx_valid[0] && lat < 6) begin
      wait_clk(1);
      lat++;
    end
    check("a_latency_le5", 32'(lat <= 5), 32'd1);
    wait_clk(2);
    sck_a = 1'b0;
    wait_clk(2);
    frame_end();
    check("a_data",  32'(rx_data[0]),    32'hA5);
    check("a_count", 32'(fifo_count[0]), 32'd1);
    check("a_idle",  32'(busy[0]),       32'd0);
    pop0();
    check("a_pop_valid", 32'(rx_valid[0]),   32'd0);
    check("a_pop_count", 32'(fifo_count[0]), 32'd0);
    check("a_pop_data",  32'(rx_data[0]),    32'd0);
    drain_others();

    // All four modes plus LSB-first: 0x3C 0xC3 in one frame
    frame_start();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    frame_end();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mode%0d_count", i), 32'(fifo_count[i]), 32'd2);
      check($sformatf("mode%0d_w0", i),    32'(rx_data[i]),    32'h3C);
    end
    pop_all();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mode%0d_w1", i), 32'(rx_data[i]), 32'hC3);
    end
    pop_all();
    // 0x01 on the wire: LSB-first instance reassembles it as 0x80
    frame_start();
    send_bits(8'h01, 8);
    frame_end();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mode%0d_w01", i), 32'(rx_data[i]), (i == 4) ? 32'h80 : 32'h01);
    end
    pop_all();
    check("m0_empty", 32'(fifo_count[0]), 32'd0);

    // Overflow: six bytes with rxReady low
    frame_start();
    for (int i = 0; i < 6; i++) begin
      send_bits(8'h10 + 8'(i), 8);
    end
    frame_end();
    check("ovf_count", 32'(fifo_count[0]), 32'd4);
    check("ovf_flag",  32'(ovf[0]),        32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_order%0d", i), 32'(rx_data[0]), 32'h10 + 32'(i));
      pop0();
    end
    check("ovf_drained", 32'(fifo_count[0]), 32'd0);
    check("ovf_held",    32'(ovf[0]),        32'd1);
    clr_0 = 1'b1;
    wait_clk(1);
    clr_0 = 1'b0;
    check("ovf_clr", 32'(ovf[0]), 32'd0);
    drain_others();

    // Frame error: cs dropped after 5 bits, then a full 0x7E
    frame_start();
    send_bits(8'hB0, 5);
    frame_end();
    check("ferr_flag",  32'(ferr[0]),       32'd1);
    check("ferr_count", 32'(fifo_count[0]), 32'd0);
    check("ferr_busy",  32'(busy[0]),       32'd0);
    frame_start();
    send_bits(8'h7E, 8);
    frame_end();
    check("ferr_next_data",  32'(rx_data[0]),    32'h7E);
    check("ferr_next_count", 32'(fifo_count[0]), 32'd1);
    pop0();
    clr_0 = 1'b1;
    wait_clk(1);
    clr_0 = 1'b0;
    check("ferr_clr", 32'(ferr[0]), 32'd0);
    drain_others();

    // Full FIFO with a pop exactly in the commit cycle of the 5th word
    frame_start();
    for (int i = 0; i < 4; i++) begin
      send_bits(8'h21 + 8'(i), 8);
    end
    check("full_count_pre", 32'(fifo_count[0]), 32'd4);
    send_bits(8'h25, 7);
    sdi = 1'b1;
    wait_clk(2);
    sck_a = 1'b1;
    wait_clk(2);
    rdy_0 = 1'b1;
    wait_clk(1);
    rdy_0 = 1'b0;
    wait_clk(1);
    sck_a = 1'b0;
    wait_clk(2);
    frame_end();
    check("full_no_ovf", 32'(ovf[0]),        32'd0);
    check("full_count",  32'(fifo_count[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_order%0d", i), 32'(rx_data[0]), 32'h22 + 32'(i));
      pop0();
    end
    check("full_drained", 32'(fifo_count[0]), 32'd0);
    drain_others();

    // Asynchronous reset with two words queued and a word in progress
    frame_start();
    send_bits(8'h31, 8);
    send_bits(8'h32, 8);
    frame_end();
    check("rst2_count", 32'(fifo_count[0]), 32'd2);
    frame_start();
    send_bits(8'hF0, 4);
    sdi = 1'b1;
    wait_clk(2);
    sck_a = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rx_valid[0]),   32'd0);
    check("arst_count", 32'(fifo_count[0]), 32'd0);
    check("arst_data",  32'(rx_data[0]),    32'd0);
    check("arst_busy",  32'(busy[0]),       32'd0);
    sck_a = 1'b0;
    cs = 1'b0;
    sdi = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    frame_start();
    send_bits(8'h5A, 8);
    frame_end();
    check("post_rst_data",  32'(rx_data[0]),    32'h5A);
    check("post_rst_count", 32'(fifo_count[0]), 32'd1);
    check("post_rst_ferr",  32'(ferr[0]),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Parametrised SPI slave receiver, successor to the single-byte negedge receiver. It runs entirely in the system clock domain: SCK, CS and SDI are synchronised and their edges detected, so the receiver supports all four CPOL/CPHA modes, configurable word width and bit order. Completed words go into an internal first-word-fall-through FIFO with a valid/ready output handshake. Sticky flags report overflow and framing errors. It sits between the MCU SPI link and the pixel/line-buffer logic of the edge-detection accelerator.

## Interface
- DATA_BITS, 8: bits per received word (2..32).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on the leading SCK edge; 1 = sample on the trailing SCK edge.
- MSB_FIRST, 1: 1 = first received bit lands in bit DATA_BITS-1; 0 = it lands in bit 0.
- FIFO_DEPTH, 4: number of output FIFO entries; must be a power of two, 2 or more.

- clk  in  1  system clock; must run at least 4x the SCK frequency.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock, asynchronous to clk.
- sdi  in  1  SPI data in, asynchronous to clk.
- cs  in  1  chip select, active-high, asynchronous to clk.
- rxReady  in  1  downstream accepts the word on rxData.
- clrErr  in  1  single-cycle pulse that clears overflow and frameErr.
- rxData  out  DATA_BITS  oldest FIFO word (FWFT); 0 when the FIFO is empty.
- rxValid  out  1  FIFO not empty.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- frameErr  out  1  sticky: cs deasserted mid-word.
- busy  out  1  state is SHIFT.

## Operation
- **Synchronisers.** sck, sdi and cs each pass through two flops. Edge detection uses a third sck flop.
- **Edges.** The sample edge is the rising edge when CPOL equals CPHA, and the falling edge otherwise. Only synchronised sample edges are used; the other edge is ignored.
- **State machine.**
  - IDLE: bit counter = 0. Go to SHIFT when synchronised cs is 1.
  - SHIFT: on each sample edge, shift the synchronised sdi into the register and increment the counter. When the counter reaches DATA_BITS, commit the word, clear the counter and stay in SHIFT. If cs drops, go to IDLE.
  - There is no separate DONE state. The commit is a single-cycle internal pulse.
- **Bit order.**
  - MSB_FIRST = 1: shift left, inserting at bit 0.
  - MSB_FIRST = 0: shift right, inserting at bit DATA_BITS-1.
- **cs deassertion.**
  - With counter = 0: go to IDLE silently.
  - With counter > 0: discard the partial word, set frameErr, go to IDLE.
  - A sample edge in the same cycle that cs is seen low is ignored.
- **FIFO.**
  - Push on commit. Pop when rxValid and rxReady are both 1.
  - Pointers wrap modulo FIFO_DEPTH. fifoCount is tracked separately.
  - Commit while full: the word is dropped and overflow is set, unless a pop occurs in the same cycle. Push and pop together while full means both happen; fifoCount is unchanged and there is no overflow.
  - Push and pop together while empty is impossible, because rxValid is 0.
- **Error flags.**
  - clrErr clears both flags on the next edge.
  - If a set event coincides with clrErr, the flag ends up set.
- **Reset.** rst, asynchronous and active-high, clears:
  - the state (to IDLE), counter, shift register, all synchroniser flops (sck flops to CPOL), and FIFO pointers and count;
  - all outputs to 0.
  - Reset mid-word or mid-burst discards everything. After reset, shifting needs a fresh synchronised cs high.

## Timing
- Input to synchronised value: 2 clk cycles. Edge-detect pulse: 1 further cycle.
- Final sample edge on the pin to rxValid high, FIFO previously empty: at most 5 clk cycles.
  - Edge pulse at cycle N, shift plus commit at N+1 edge, push registered at N+1.
  - rxValid and rxData are valid from the cycle after the push.
- rxData is combinational from the FIFO read pointer. It changes the cycle after a pop.
- Back-to-back words have no dead bit. Bit 0 of word k+1 may be sampled on the SCK edge right after the last bit of word k.
- Setup: cs must be high at least 3 clk cycles before the first sample edge. Shorter setup is not guaranteed.
- Throughput: one pop per clk cycle at most.

## Test plan
- **Mode 0, MSB_FIRST, DATA_BITS=8, clk = 8x sck, one frame 0xA5** -> rxValid within 5 clk of the 8th rising SCK edge; rxData = 0xA5; pop with rxReady -> rxValid = 0, fifoCount = 0.
- **All four CPOL/CPHA combinations, bytes 0x3C 0xC3, plus MSB_FIRST=0 run** -> exact bytes in every mode; LSB-first 0x01 on the wire yields 0x80.
- **rxReady held 0, six bytes 0x10..0x15, FIFO_DEPTH=4** -> fifoCount saturates at 4, overflow = 1; drained order is 0x10..0x13; clrErr -> overflow = 0.
- **cs dropped after 5 bits, then a full byte 0x7E** -> frameErr = 1, no partial word pushed; next word reads 0x7E.
- **FIFO full with rxReady = 1 exactly on the commit cycle** -> no overflow; fifoCount stays 4; ordering preserved.
- **rst pulsed mid-word and with 2 words queued** -> outputs are 0 immediately (asynchronous); new frame 0x5A after release is received correctly.
